// File: rtl/mmm_result_collector_pkg.sv
// mmm_result_collector_pkg: FSM state encodings, counter sizing and word-count helpers shared by the collector slice
package mmm_result_collector_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DRAIN = 2'd2} state_t;
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int nw_of(input int k, input int w);
    return k / w;
  endfunction
endpackage

// File: rtl/mmm_result_collector_if.sv
// mmm_result_collector_if: carry-save word input (E_IN, WV_IN, SR_INs, SR_INc) and resolved-word output stream (RES_*, BUSY, OVF_ERR)
interface mmm_result_collector_if #(parameter int W = 16);
  logic E_IN;
  logic WV_IN;
  logic [W-1:0] SR_INs;
  logic [W-1:0] SR_INc;
  logic [W-1:0] RES_OUT;
  logic RES_VALID;
  logic RES_READY;
  logic RES_LAST;
  logic RES_MSB;
  logic BUSY;
  logic OVF_ERR;
  modport master (output E_IN, WV_IN, SR_INs, SR_INc, RES_READY,
                  input RES_OUT, RES_VALID, RES_LAST, RES_MSB, BUSY, OVF_ERR);
  modport slave (input E_IN, WV_IN, SR_INs, SR_INc, RES_READY,
                 output RES_OUT, RES_VALID, RES_LAST, RES_MSB, BUSY, OVF_ERR);
endinterface

// File: rtl/mmm_result_collector_cs_word_adder.sv
// mmm_result_collector_cs_word_adder: combinational W-bit s + c + cin -> sum, cout
module mmm_result_collector_cs_word_adder #(parameter int W = 16) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] c,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, s} + {1'b0, c} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mmm_result_collector.sv
// mmm_result_collector: buffers NW carry-save words resolved LSW-first, drains them on a valid/ready stream; ports CLK, RST, bus (slave)
module mmm_result_collector
  import mmm_result_collector_pkg::*;
#(
  parameter int K = 1024,
  parameter int W = 16
) (
  input logic CLK,
  input logic RST,
  mmm_result_collector_if.slave bus
);
  localparam int NW = nw_of(K, W);
  localparam int CW = clogb2(NW);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  state_t state_q, state_d;
  logic [CW-1:0] wcnt, rcnt, rnxt;
  logic [W-1:0] mem [0:(2**CW)-1];
  logic [W-1:0] sum, res_out;
  logic cy, cin, cout, res_last, res_msb, ovf;
  logic acc, wr_last, abort, hs, rd_last;
  mmm_result_collector_cs_word_adder #(.W(W)) u_add (
    .s(bus.SR_INs), .c(bus.SR_INc), .cin(cin), .sum(sum), .cout(cout)
  );
  always_comb begin
    acc = bus.WV_IN & bus.E_IN & (state_q != S_DRAIN);
    wr_last = acc & (wcnt == LAST);
    abort = (state_q == S_COLLECT) & ~bus.E_IN;
    hs = (state_q == S_DRAIN) & bus.RES_READY;
    rd_last = rcnt == LAST;
    rnxt = rcnt + CW'(1);
    cin = (state_q == S_IDLE) ? 1'b0 : cy;
    state_d = abort ? S_IDLE : wr_last ? S_DRAIN : acc ? S_COLLECT : (hs & rd_last) ? S_IDLE : state_q;
  end
  always_ff @(posedge CLK) if (acc) mem[wcnt] <= sum;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wcnt <= '0;
      rcnt <= '0;
      cy <= 1'b0;
      res_out <= '0;
      res_last <= 1'b0;
      res_msb <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state_q <= state_d;
      cy <= abort ? 1'b0 : acc ? cout : cy;
      wcnt <= (abort | wr_last) ? '0 : acc ? wcnt + CW'(1) : wcnt;
      rcnt <= wr_last ? '0 : hs ? rnxt : rcnt;
      res_msb <= wr_last ? cout : res_msb;
      res_out <= wr_last ? ((NW == 1) ? sum : mem[0]) : (hs & ~rd_last) ? mem[rnxt] : res_out;
      res_last <= wr_last ? (NW == 1) : hs ? (rnxt == LAST) : res_last;
      ovf <= ovf | ((state_q == S_DRAIN) & bus.WV_IN);
    end
  end
  assign bus.RES_OUT = res_out;
  assign bus.RES_VALID = state_q == S_DRAIN;
  assign bus.RES_LAST = res_last;
  assign bus.RES_MSB = res_msb;
  assign bus.BUSY = state_q != S_IDLE;
  assign bus.OVF_ERR = ovf;
endmodule
